// File: rtl/pq_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pq_arb_pkg                                                       |
// | Brief   : Widths, field positions, FSM states and pipeline token for the   |
// |           shared priority-queue path arbiter.                              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pq_arb_pkg;

    localparam int KEY_W = 31;
    localparam int TAG_W = 32;
    localparam int CMD_W = 65;
    localparam int RSP_W = 66;
    localparam int ID_W  = 3;

    localparam int CMD_VALID   = 64;
    localparam int CMD_PUSH    = 63;
    localparam int CMD_KEY_LSB = 32;
    localparam int CMD_TAG_LSB = 0;

    localparam int RSP_VALID   = 65;
    localparam int RSP_EMPTY   = 64;
    localparam int RSP_FULL    = 63;
    localparam int RSP_KEY_LSB = 32;
    localparam int RSP_TAG_LSB = 0;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            is_pop;
        logic            err;
    } tok_t;

endpackage
`default_nettype wire

// File: rtl/pq_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pq_rr_arbiter                                                    |
// | Brief   : Combinational round-robin grant with a registered pointer.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pq_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic                       i_en,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id
);

    localparam int c_ptr_w = $clog2(NUM_REQ);

    logic [c_ptr_w-1:0] r_ptr;
    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_hi;
    logic [NUM_REQ-1:0] w_pick;

    // Requesters strictly above the pointer win first; otherwise wrap to the lowest.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_mask
        assign w_mask[i] = (i > int'(r_ptr));
    end

    assign w_hi    = i_req & w_mask;
    assign w_pick  = (|w_hi) ? w_hi : i_req;
    assign o_grant = w_pick & (~w_pick + NUM_REQ'(1));

    always_comb begin
        o_grant_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (o_grant[i]) o_grant_id = c_ptr_w'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= c_ptr_w'(NUM_REQ - 1);
        end else if (i_en && (|o_grant)) begin
            r_ptr <= o_grant_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pq_path_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pq_path_arbiter                                                  |
// | Brief   : Shares one priority-queue path between requesters; tracks        |
// |           occupancy, rejects overflow/underflow, routes pop results, and   |
// |           drains on flush. Optional counters under PQ_ARB_STATS_EN.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pq_path_arbiter
    import pq_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DEPTH    = 16,
    parameter int PATH_LAT = 2
) (
    input  logic                         system1000,
    input  logic                         system1000_rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_push,
    input  logic [NUM_REQ*KEY_W-1:0]     req_key,
    input  logic [NUM_REQ*TAG_W-1:0]     req_tag,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [KEY_W-1:0]             rsp_key,
    output logic [TAG_W-1:0]             rsp_tag,
    output logic                         rsp_err,
    input  logic                         flush,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [CMD_W-1:0]             pq_cmd,
    input  logic [RSP_W-1:0]             pq_rsp
`ifdef PQ_ARB_STATS_EN
    ,
    output logic [31:0]                  stat_push,
    output logic [31:0]                  stat_pop,
    output logic [31:0]                  stat_rej
`endif
);

    localparam int c_occ_w = $clog2(DEPTH + 1);
    localparam int c_id_w  = $clog2(NUM_REQ);

    state_t             r_state, w_state_nxt;
    logic [c_occ_w-1:0] r_occ, w_occ_nxt;
    logic [CMD_W-1:0]   r_cmd, w_cmd_nxt;
    tok_t               r_pipe [PATH_LAT];
    tok_t               w_tok, w_out;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic               r_rsp_err;
    logic [KEY_W-1:0]   r_rsp_key;
    logic [TAG_W-1:0]   r_rsp_tag;

    logic [NUM_REQ-1:0] w_grant;
    logic [c_id_w-1:0]  w_gid;
    logic               w_run_ok, w_not_full, w_not_empty, w_pipe_busy, w_bad;
    logic [KEY_W-1:0]   w_key;
    logic [TAG_W-1:0]   w_tag;
    logic               w_unused_full;

    assign w_run_ok = (r_state == RUN) && !flush;

    pq_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk        (system1000),
        .rst        (system1000_rst),
        .i_req      (req_valid),
        .i_en       (w_run_ok),
        .o_grant    (w_grant),
        .o_grant_id (w_gid)
    );

    assign req_ready     = w_grant & {NUM_REQ{w_run_ok}};
    assign w_key         = req_key[w_gid*KEY_W +: KEY_W];
    assign w_tag         = req_tag[w_gid*TAG_W +: TAG_W];
    assign w_not_full    = (r_occ < c_occ_w'(DEPTH));
    assign w_not_empty   = (r_occ != '0);
    assign w_out         = r_pipe[PATH_LAT-1];
    assign w_unused_full = pq_rsp[RSP_FULL];

    always_comb begin
        w_pipe_busy = 1'b0;
        for (int i = 0; i < PATH_LAT; i++) begin
            w_pipe_busy = w_pipe_busy | r_pipe[i].valid;
        end
    end

    // Occupancy moves at issue time so in-flight ops can never over/underflow the path.
    always_comb begin
        w_state_nxt = r_state;
        w_occ_nxt   = r_occ;
        w_cmd_nxt   = '0;
        w_tok       = '0;
        case (r_state)
            RUN: begin
                if (flush) begin
                    w_state_nxt = DRAIN;
                end else if (|w_grant) begin
                    w_tok.valid = 1'b1;
                    w_tok.id    = ID_W'(w_gid);
                    if (req_push[w_gid]) begin
                        if (w_not_full) begin
                            w_cmd_nxt[CMD_VALID]               = 1'b1;
                            w_cmd_nxt[CMD_PUSH]                = 1'b1;
                            w_cmd_nxt[CMD_KEY_LSB +: KEY_W]    = w_key;
                            w_cmd_nxt[CMD_TAG_LSB +: TAG_W]    = w_tag;
                            w_occ_nxt                          = r_occ + c_occ_w'(1);
                        end else begin
                            w_tok.err = 1'b1;
                        end
                    end else if (w_not_empty) begin
                        w_cmd_nxt[CMD_VALID] = 1'b1;
                        w_occ_nxt            = r_occ - c_occ_w'(1);
                        w_tok.is_pop         = 1'b1;
                    end else begin
                        w_tok.err = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Drain pops carry a token only so the exit waits for the path to go quiet.
                if (w_not_empty) begin
                    w_cmd_nxt[CMD_VALID] = 1'b1;
                    w_occ_nxt            = r_occ - c_occ_w'(1);
                    w_tok.valid          = 1'b1;
                end else if (!w_pipe_busy) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    assign w_bad = w_out.err | ~pq_rsp[RSP_VALID] | pq_rsp[RSP_EMPTY];

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            r_state     <= RUN;
            r_occ       <= '0;
            r_cmd       <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_key   <= '0;
            r_rsp_tag   <= '0;
            for (int i = 0; i < PATH_LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_occ     <= w_occ_nxt;
            r_cmd     <= w_cmd_nxt;
            r_pipe[0] <= w_tok;
            for (int i = 1; i < PATH_LAT; i++) r_pipe[i] <= r_pipe[i-1];
            if (w_out.valid && (w_out.is_pop || w_out.err)) begin
                r_rsp_valid <= NUM_REQ'(1) << w_out.id;
                r_rsp_err   <= w_bad;
                r_rsp_key   <= w_bad ? '0 : pq_rsp[RSP_KEY_LSB +: KEY_W];
                r_rsp_tag   <= w_bad ? '0 : pq_rsp[RSP_TAG_LSB +: TAG_W];
            end else begin
                r_rsp_valid <= '0;
                r_rsp_err   <= 1'b0;
                r_rsp_key   <= '0;
                r_rsp_tag   <= '0;
            end
        end
    end

    assign pq_cmd    = r_cmd;
    assign occupancy = r_occ;
    assign busy      = (r_state == DRAIN);
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_key   = r_rsp_key;
    assign rsp_tag   = r_rsp_tag;

`ifdef PQ_ARB_STATS_EN
    logic [31:0] r_stat_push, r_stat_pop, r_stat_rej;

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            r_stat_push <= '0;
            r_stat_pop  <= '0;
            r_stat_rej  <= '0;
        end else begin
            if (w_cmd_nxt[CMD_VALID] && w_cmd_nxt[CMD_PUSH]) r_stat_push <= r_stat_push + 32'd1;
            if (w_tok.valid && w_tok.is_pop)                 r_stat_pop  <= r_stat_pop + 32'd1;
            if (w_tok.err)                                   r_stat_rej  <= r_stat_rej + 32'd1;
        end
    end

    assign stat_push = r_stat_push;
    assign stat_pop  = r_stat_pop;
    assign stat_rej  = r_stat_rej;
`endif

endmodule
`default_nettype wire

// File: doc/pq_path_arbiter.md
Name: pq_path_arbiter

Overview:
- Shares one priority-queue path instance between NUM_REQ requesters.
- Round-robin grants at most one push/pop per cycle and drives the path's 65-bit command word.
- Tracks queue occupancy and rejects push-when-full and pop-when-empty.
- Routes pop results in the 66-bit path response back to the issuing requester; a flush request drains the queue.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DEPTH, 16, path capacity in entries.
- PATH_LAT, 2, cycles from pq_cmd register to matching pq_rsp (>=1).

Ports:
- system1000  in  1  clock
- system1000_rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester op valid
- req_push  in  NUM_REQ  1=push, 0=pop
- req_key  in  NUM_REQ*31  packed keys; requester i at [31*i +: 31]
- req_tag  in  NUM_REQ*32  packed tags
- req_ready  out  NUM_REQ  one-hot grant; accepted when valid&ready
- rsp_valid  out  NUM_REQ  one-hot response strobe
- rsp_key  out  31  popped key
- rsp_tag  out  32  popped tag
- rsp_err  out  1  op was rejected (full/empty)
- flush  in  1  pulse: drain queue
- busy  out  1  high while draining
- occupancy  out  $clog2(DEPTH+1)  committed entry count
- pq_cmd  out  65  {valid, is_push, key[30:0], tag[31:0]}
- pq_rsp  in  66  {valid, empty, full, key[30:0], tag[31:0]}

Behaviour:
- Reset (synchronous, system1000_rst=1) sets pq_cmd=0, rsp_valid=0, rsp_err=0, rsp_key/rsp_tag=0, occupancy=0, busy=0, state=RUN, RR pointer=NUM_REQ-1 (requester 0 wins first), response pipeline cleared. Any in-flight op is dropped.
- FSM states:
  - RUN: grant the first valid requester after the pointer, wrapping. req_ready is combinational from req_valid and the pointer. The pointer updates to the grantee only on a grant.
  - DRAIN: entered on flush when state=RUN; flush has priority over grants that cycle, so req_ready=0. Issue one pop per cycle while occupancy>0. When occupancy==0 and the pipeline is empty, return to RUN. flush while in DRAIN is ignored.
- Issue rule on grant:
  - push with occupancy<DEPTH: pq_cmd={1,1,key,tag}, occupancy+1.
  - pop with occupancy>0: pq_cmd={1,0,0,0}, occupancy-1.
  - Otherwise the op is rejected: pq_cmd valid=0, and an error token enters the pipeline.
  - occupancy changes at issue time, so there is no over/underflow with ops in flight.
- pq_cmd is registered. Accept→rsp latency is exactly 1+PATH_LAT cycles.
- Shift pipeline, PATH_LAT deep: {valid, id, is_pop, err}.
  - At the output: pop → rsp_valid[id]=1 with key/tag from pq_rsp.
  - err → rsp_valid[id]=1, rsp_err=1, key/tag=0.
  - Successful push → no response.
  - Drain pops → response discarded.
- Pop token arriving with pq_rsp.valid=0 or pq_rsp.empty=1 → respond with rsp_err=1 (path inconsistency).
- rsp_* outputs are valid for one cycle only; there is no backpressure on responses.

Optional Feature:
- PQ_ARB_STATS_EN defined:
  - Adds outputs stat_push, stat_pop, stat_rej (32 bits each).
  - Counters increment on successful push, successful requester pop, and rejection respectively.
  - Counters wrap at 2^32, reset to 0, and do not count drain pops.
- Undefined: no counters and no extra ports.

Decomposition:
- Package pq_arb_pkg holds:
  - KEY_W=31, TAG_W=32, CMD_W=65, RSP_W=66.
  - Field bit positions for cmd/rsp.
  - FSM state typedef {RUN, DRAIN}.
  - Pipeline token struct.
- Sub-module pq_rr_arbiter: NUM_REQ-wide combinational round-robin grant plus registered pointer, with an enable input for pointer update.

Test Plan:
- After reset, requesters 0 and 2 both push (key 5, 9) in the same cycle → grant 0 first, 2 next cycle; occupancy 1 then 2; no rsp.
- Requester 1 pops with queue {5,9} and path returning min → rsp_valid=4'b0010 exactly 1+PATH_LAT=3 cycles after accept, rsp_key=5, rsp_err=0.
- All 4 requesters hold valid continuously → grants rotate 0,1,2,3,0; each req_ready pulses once per 4 cycles.
- Fill to DEPTH=16, then push → rsp_err=1 to that requester at latency 3, pq_cmd.valid=0, occupancy stays 16. Pop on empty → rsp_err=1, occupancy 0.
- Occupancy 3, flush → busy=1, req_ready=0, three drain pops issued, no rsp_valid; busy drops once the pipeline is empty, and grants resume.
- system1000_rst asserted with pops in flight → next cycle rsp_valid=0, occupancy=0, pq_cmd=0; stale pq_rsp is ignored.
